ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-requester arbiter and sequencer for the data port of the dual-port program/data RAM in the RISC-V SoC top. It shares the single RAM data port between the CPU data bus (requester 0) and a second master such as the UART program loader or a DMA engine (requester 1). Per access it:
- decodes byte enables from size and address;
- range-checks the address;
- routes each 1-cycle-latency read response back to the requester that issued it.

## Interface
Parameters:
- `WL`, 32: data word width in bits; multiple of 8.
- `NB_COL`, `WL/8`: byte lanes per word.
- `RAM_DEPTH`, 8192: RAM depth in words.
- `RAM_ADDR_WL`, `$clog2(RAM_DEPTH-1)`: RAM word-address width.
- `SIZE_WL`, 2: width of the access-size field.

Ports (x = 0, 1):
- `clk`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `mx_cmd_valid`, in, 1: requester x has a command.
- `mx_cmd_ready`, out, 1: command from x accepted this cycle.
- `mx_cmd_wr`, in, 1: 1 = write, 0 = read.
- `mx_cmd_addr`, in, WL: byte address.
- `mx_cmd_data`, in, WL: write data, already lane-replicated by the requester.
- `mx_cmd_size`, in, SIZE_WL: access size; 0 = byte, 1 = half, 2/3 = word.
- `mx_rsp_valid`, out, 1: read response for x.
- `mx_rsp_error`, out, 1: the read was out of range; qualified by `mx_rsp_valid`.
- `mx_rsp_data`, out, WL: read data.
- `ram_we`, out, NB_COL: per-lane write enable.
- `ram_addr`, out, RAM_ADDR_WL: word address.
- `ram_din`, out, WL: write data.
- `ram_dout`, in, WL: read data, valid one cycle after the address.
- `grant_id`, out, 1: requester granted this cycle; valid when any `cmd_ready` is high.

## Operation

Arbitration:
- At most one command is accepted per cycle.
- One valid requester: it is granted.
- Both valid: round-robin. The requester not granted last is granted.
- The last-grant register updates only when a grant is issued.

Ready and mux:
- `mx_cmd_ready` is combinational: valid AND granted. It does not depend on `ready` from the other side.
- The RAM-side mux always follows the winner.
- With no request: `ram_we = 0`, and `ram_addr`/`ram_din` are don't-care.

Byte enables:
- `lane = pattern << addr[1:0]`, truncated to NB_COL bits.
- pattern: size 0 → `0001`, size 1 → `0011`, size 2/3 → all ones.
- No misalignment fault. Any lanes shifted past the MSB are dropped.

Range check:
- `addr[WL-1:RAM_ADDR_WL+2]` non-zero means out of range.
- Out-of-range write: `ram_we` forced to 0, the command is still accepted, and no response is produced.
- Out-of-range read: the command is accepted; the response has `rsp_error = 1` and `rsp_data = 0`.

Addressing and writes:
- `ram_addr = addr[RAM_ADDR_WL+1:2]`.
- Writes produce no response.

Response routing:
- A pipeline register holds `{pending, id, error}` for the read accepted in cycle N.
- In cycle N+1, `m<id>_rsp_valid = 1` and `m<id>_rsp_data = ram_dout` (or 0 on error).
- The other requester's `rsp_valid` stays 0.

## Timing
- Command to RAM: 0 cycles (combinational mux). Read response: exactly 1 cycle after acceptance.
- Throughput: one access per cycle total. Under contention, each requester gets one access every 2 cycles.
- Back-to-back reads by the same or alternating requesters are fully pipelined. Every accepted read yields exactly one response.
- Same-cycle events:
  - A response to one requester may coincide with a grant to either requester.
  - A write at address A in cycle N followed by a read of A in cycle N+1 returns the new data. This relies on the RAM's write-first / no-change behaviour at a different cycle; no bypass is needed.
- Reset values:
  - `mx_rsp_valid = 0`, `mx_rsp_error = 0`, `mx_rsp_data = 0`.
  - `pending = 0`, `grant_id = 0`.
  - last-grant = 1, so m0 wins the first tie.
- Reset while a read is in flight: the response is dropped; no `rsp_valid` appears after reset.
- `mx_cmd_ready` is 0 while `reset` is high.

## Structure
- Shared package `ram_arb_pkg`:
  - access-size enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - requester index constants (`REQ_CPU = 0`, `REQ_AUX = 1`);
  - response-pipeline struct `{pending, id, error}`.
- One sub-module: `ram_byte_enable_dec`, which maps (size, addr[1:0]) to lane enables. It is purely combinational and is reused by the top-level dBus path.
- Arbitration, range check and the response pipeline live in the top module.

## Test plan
- Single requester: m0 writes word `0xDEADBEEF` at `0x10`, then reads `0x10`. `ram_we = 1111` and `ram_addr = 4`; read `rsp_valid` 1 cycle later with `0xDEADBEEF`; `m1_rsp_valid` stays 0.
- Byte/half lanes: m1 size 0 at `0x23` → `ram_we = 1000`; size 1 at `0x22` → `1100`; size 1 at `0x23` → `1000`.
- Contention: both hold reads for 6 cycles → grants m0, m1, m0, m1, m0, m1 after reset. Each response returns to the correct requester 1 cycle after its grant, with that requester's data.
- Out of range: m0 reads `0x0000_8000` (RAM_DEPTH = 8192) → `rsp_valid = 1`, `rsp_error = 1`, `rsp_data = 0`. m0 writes there → `ram_we = 0`, `cmd_ready = 1`.
- Reset mid-read: accept an m1 read, assert `reset` in the next cycle → `m1_rsp_valid` stays 0 through and after reset. First tie after reset is granted to m0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM data-port arbiter: access sizes, requester ids
// and the one-stage read-response pipeline record.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   typedef struct packed {
      logic pending;
      logic id;
      logic error;
   } rsp_pipe_t;

endpackage

// File: rtl/ram_byte_enable_dec.sv
// Maps access size and byte offset to per-lane write enables; purely combinational.
// Lanes shifted past the top of the word are dropped, so there is no misalignment fault.
module ram_byte_enable_dec
   import ram_arb_pkg::*;
#(
   parameter int NB_COL  = 4,
   parameter int SIZE_WL = 2
) (
   input  logic [SIZE_WL-1:0] size,
   input  logic [1:0]         offset,
   output logic [NB_COL-1:0]  lane
);

   logic [NB_COL-1:0] pattern;

   always_comb begin
      pattern = '1;
      if (size == SIZE_WL'(SZ_BYTE))
         pattern = NB_COL'(1);
      else if (size == SIZE_WL'(SZ_HALF))
         pattern = NB_COL'(3);
   end

   assign lane = pattern << offset;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM data port between two requesters; commands reach the RAM
// combinationally, read responses return one cycle after acceptance; ready is valid AND granted.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int WL          = 32,
   parameter int NB_COL      = WL / 8,
   parameter int RAM_DEPTH   = 8192,
   parameter int RAM_ADDR_WL = $clog2(RAM_DEPTH - 1),
   parameter int SIZE_WL     = 2
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   m0_cmd_valid,
   output logic                   m0_cmd_ready,
   input  logic                   m0_cmd_wr,
   input  logic [WL-1:0]          m0_cmd_addr,
   input  logic [WL-1:0]          m0_cmd_data,
   input  logic [SIZE_WL-1:0]     m0_cmd_size,
   output logic                   m0_rsp_valid,
   output logic                   m0_rsp_error,
   output logic [WL-1:0]          m0_rsp_data,

   input  logic                   m1_cmd_valid,
   output logic                   m1_cmd_ready,
   input  logic                   m1_cmd_wr,
   input  logic [WL-1:0]          m1_cmd_addr,
   input  logic [WL-1:0]          m1_cmd_data,
   input  logic [SIZE_WL-1:0]     m1_cmd_size,
   output logic                   m1_rsp_valid,
   output logic                   m1_rsp_error,
   output logic [WL-1:0]          m1_rsp_data,

   output logic [NB_COL-1:0]      ram_we,
   output logic [RAM_ADDR_WL-1:0] ram_addr,
   output logic [WL-1:0]          ram_din,
   input  logic [WL-1:0]          ram_dout,

   output logic                   grant_id
);

   logic              last_grant;
   logic              winner;
   logic              grant;
   logic              sel_wr;
   logic [WL-1:0]     sel_addr;
   logic [WL-1:0]     sel_data;
   logic [SIZE_WL-1:0] sel_size;
   logic [NB_COL-1:0] lane;
   logic              oor;
   rsp_pipe_t         pipe;
   rsp_pipe_t         pipe_nxt;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      winner = REQ_CPU;
      if (m0_cmd_valid && m1_cmd_valid)
         winner = ~last_grant;
      else if (m1_cmd_valid)
         winner = REQ_AUX;
   end

   assign grant        = (m0_cmd_valid || m1_cmd_valid) && !reset;
   assign m0_cmd_ready = m0_cmd_valid && !reset && (winner == REQ_CPU);
   assign m1_cmd_ready = m1_cmd_valid && !reset && (winner == REQ_AUX);
   assign grant_id     = winner && !reset;

   always_comb begin
      sel_wr   = m0_cmd_wr;
      sel_addr = m0_cmd_addr;
      sel_data = m0_cmd_data;
      sel_size = m0_cmd_size;
      if (winner == REQ_AUX) begin
         sel_wr   = m1_cmd_wr;
         sel_addr = m1_cmd_addr;
         sel_data = m1_cmd_data;
         sel_size = m1_cmd_size;
      end
   end

   ram_byte_enable_dec #(
      .NB_COL  (NB_COL),
      .SIZE_WL (SIZE_WL)
   ) u_be_dec (
      .size   (sel_size),
      .offset (sel_addr[1:0]),
      .lane   (lane)
   );

   assign oor      = |sel_addr[WL-1:RAM_ADDR_WL+2];
   assign ram_we   = (grant && sel_wr && !oor) ? lane : '0;
   assign ram_addr = sel_addr[RAM_ADDR_WL+1:2];
   assign ram_din  = sel_data;

   always_comb begin
      pipe_nxt.pending = grant && !sel_wr;
      pipe_nxt.id      = winner;
      pipe_nxt.error   = oor;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe       <= '0;
         last_grant <= REQ_AUX;
      end else begin
         pipe <= pipe_nxt;
         if (grant)
            last_grant <= winner;
      end
   end

   // Gating with reset drops a response whose read was accepted just before reset rose.
   assign m0_rsp_valid = pipe.pending && !reset && (pipe.id == REQ_CPU);
   assign m1_rsp_valid = pipe.pending && !reset && (pipe.id == REQ_AUX);
   assign m0_rsp_error = m0_rsp_valid && pipe.error;
   assign m1_rsp_error = m1_rsp_valid && pipe.error;
   assign m0_rsp_data  = (m0_rsp_valid && !pipe.error) ? ram_dout : '0;
   assign m1_rsp_data  = (m1_rsp_valid && !pipe.error) ? ram_dout : '0;

endmodule
